// File: rtl/icache_axi_rd_arbiter.sv
// icache_axi_rd_arbiter
// Round-robin arbiter that shares one AXI4 read channel (AR + R) between
// NUM_REQ instruction-cache miss engines. One requester owns the channel
// from grant until the R beat carrying RLAST has been accepted.
//
// Optional feature: define ICACHE_RD_ARB_STATS_EN to add o_grant_cnt, one
// saturating 32-bit counter per requester of completed AR handshakes.
//
// Handshake semantics: a transfer happens on a rising i_clk edge where both
// valid and ready of that channel are high. Valid never waits on ready. The
// owner's i_rready is forwarded unchanged to o_m_rready, and i_m_arready is
// forwarded to the owner's o_arready, so no beat is buffered or dropped here.
// Debug visibility: o_grant is the owner index, o_busy is high while the
// FSM is in ADDR or DATA.
module icache_axi_rd_arbiter #(
  parameter  int NUM_REQ   = 2,
  parameter  int ADDR_SIZE = 32,
  parameter  int DATA_SIZE = 32,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_areset_n,
  // requester side
  input  logic [NUM_REQ-1:0]           i_arvalid,
  input  logic [NUM_REQ*ADDR_SIZE-1:0] i_araddr,
  input  logic [NUM_REQ*8-1:0]         i_arlen,
  output logic [NUM_REQ-1:0]           o_arready,
  output logic [NUM_REQ-1:0]           o_rvalid,
  output logic [DATA_SIZE-1:0]         o_rdata,
  output logic                         o_rlast,
  input  logic [NUM_REQ-1:0]           i_rready,
  // memory side
  output logic                         o_m_arvalid,
  output logic [ADDR_SIZE-1:0]         o_m_araddr,
  output logic [7:0]                   o_m_arlen,
  output logic [2:0]                   o_m_arsize,
  output logic [1:0]                   o_m_arburst,
  input  logic                         i_m_arready,
  input  logic                         i_m_rvalid,
  input  logic [DATA_SIZE-1:0]         i_m_rdata,
  input  logic                         i_m_rlast,
  output logic                         o_m_rready,
  // debug
  output logic [GW-1:0]                o_grant,
  output logic                         o_busy
`ifdef ICACHE_RD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]        o_grant_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t                 state_q;
  logic [GW-1:0]          rr_ptr_q;
  logic [GW-1:0]          rr_ptr_d;
  logic [GW-1:0]          grant_q;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [7:0]             len_q;
  logic                   m_arvalid_q;
  logic                   busy_q;

  logic                   pick_vld;
  logic [GW-1:0]          pick_idx;
  logic                   ar_hs;
  logic                   r_last_hs;

  // Pick the first requesting index at or after rr_ptr, wrapping around.
  always_comb begin
    int cand;
    cand     = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!pick_vld && i_arvalid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = GW'(cand);
      end
    end
  end

  // The requester after the current owner gets first chance next time.
  always_comb begin
    rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  end

  assign ar_hs     = (state_q == S_ADDR) && i_m_arready;
  assign r_last_hs = (state_q == S_DATA) && i_m_rvalid && i_rready[grant_q] && i_m_rlast;

  // Arbitration FSM; grant, request and memory AR outputs are registered.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      m_arvalid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            grant_q     <= pick_idx;
            addr_q      <= i_araddr[pick_idx*ADDR_SIZE +: ADDR_SIZE];
            len_q       <= i_arlen[pick_idx*8 +: 8];
            m_arvalid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (ar_hs) begin
            m_arvalid_q <= 1'b0;
            state_q     <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_last_hs) begin
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          m_arvalid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // Route the memory handshakes to and from the current owner only.
  always_comb begin
    o_arready  = '0;
    o_rvalid   = '0;
    o_m_rready = 1'b0;
    o_rdata    = '0;
    o_rlast    = 1'b0;
    if (state_q == S_ADDR) begin
      o_arready[grant_q] = i_m_arready;
    end
    if (state_q == S_DATA) begin
      o_m_rready        = i_rready[grant_q];
      o_rvalid[grant_q] = i_m_rvalid;
      o_rdata           = i_m_rdata;
      o_rlast           = i_m_rlast;
    end
  end

  assign o_m_arvalid = m_arvalid_q;
  assign o_m_araddr  = addr_q;
  assign o_m_arlen   = len_q;
  assign o_m_arsize  = 3'd2;   // 4-byte beats
  assign o_m_arburst = 2'b01;  // INCR
  assign o_grant     = grant_q;
  assign o_busy      = busy_q;

`ifdef ICACHE_RD_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] cnt_q;
  logic [NUM_REQ-1:0][31:0] cnt_d;

  // Count AR handshakes per owner, sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (ar_hs && (cnt_q[grant_q] != 32'hFFFF_FFFF)) begin
      cnt_d[grant_q] = cnt_q[grant_q] + 32'd1;
    end
  end

  // Counter storage.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_icache_axi_rd_arbiter.sv
// Testbench for icache_axi_rd_arbiter (NUM_REQ=2).
// A burst table with hand-derived owners, reset/back-pressure sequences and
// randomized bursts checked against a distance-based round-robin model.
module tb_icache_axi_rd_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int GW = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    arvalid;
  logic [N*AW-1:0] araddr;
  logic [N*8-1:0]  arlen;
  logic [N-1:0]    arready;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic            rlast;
  logic [N-1:0]    rready;
  logic            m_arvalid;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;
  logic            m_arready;
  logic            m_rvalid;
  logic [DW-1:0]   m_rdata;
  logic            m_rlast;
  logic            m_rready;
  logic [GW-1:0]   grant;
  logic            busy;
`ifdef ICACHE_RD_ARB_STATS_EN
  logic [N*32-1:0] grant_cnt;
`endif

  icache_axi_rd_arbiter #(.NUM_REQ(N), .ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .i_clk(clk), .i_areset_n(rst_n),
    .i_arvalid(arvalid), .i_araddr(araddr), .i_arlen(arlen), .o_arready(arready),
    .o_rvalid(rvalid), .o_rdata(rdata), .o_rlast(rlast), .i_rready(rready),
    .o_m_arvalid(m_arvalid), .o_m_araddr(m_araddr), .o_m_arlen(m_arlen),
    .o_m_arsize(m_arsize), .o_m_arburst(m_arburst), .i_m_arready(m_arready),
    .i_m_rvalid(m_rvalid), .i_m_rdata(m_rdata), .i_m_rlast(m_rlast),
    .o_m_rready(m_rready), .o_grant(grant), .o_busy(busy)
`ifdef ICACHE_RD_ARB_STATS_EN
    , .o_grant_cnt(grant_cnt)
`endif
  );

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];
  int exp_cnt[N];
  int model_ptr;

  typedef struct {
    logic [N-1:0] req;
    logic [7:0]   len;
    int           delay;
    int           stall_at;
    int           stall_len;
    int           exp_g;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] addr_of(input int g, input int idx);
    return AW'(32'h1000 * (g + 1) + idx * 32'h100);
  endfunction

  function automatic logic [DW-1:0] data_of(input int g, input int idx, input int beat);
    return DW'(32'hA0 + beat + idx * 32'h100 + g * 32'h1_0000);
  endfunction

  // Round-robin as a distance rule: the requester closest at or above ptr wins.
  function automatic int model_pick(input logic [N-1:0] mask, input int ptr);
    int best;
    int best_d;
    best = -1;
    best_d = N;
    for (int g = 0; g < N; g++) begin
      if (mask[g] && (((g - ptr + N) % N) < best_d)) begin
        best = g;
        best_d = (g - ptr + N) % N;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    model_ptr = 0;
    for (int g = 0; g < N; g++) exp_cnt[g] = 0;
    exp_q.delete();
  endtask

`ifdef ICACHE_RD_ARB_STATS_EN
  task automatic chk_cnt();
    for (int g = 0; g < N; g++) chk("grant_cnt", grant_cnt[g*32 +: 32], 32'(exp_cnt[g]));
  endtask
`endif

  // driver: request in IDLE, then AR phase with optional memory arready delay
  task automatic addr_phase(input logic [N-1:0] mask, input logic [7:0] len,
                            input int delay, input int exp_g, input int idx);
    for (int g = 0; g < N; g++) begin
      araddr[g*AW +: AW] = addr_of(g, idx);
      arlen[g*8 +: 8]    = (g == exp_g) ? len : (len ^ 8'h05);
    end
    arvalid = mask;
    m_arready = 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_m_arvalid", 32'(m_arvalid), 32'd0);
    chk("idle_arready", 32'(arready), 32'd0);
    tick();
    chk("ar_m_arvalid", 32'(m_arvalid), 32'd1);
    chk("ar_grant", 32'(grant), 32'(exp_g));
    chk("ar_addr", m_araddr, addr_of(exp_g, idx));
    chk("ar_len", 32'(m_arlen), 32'(len));
    chk("ar_busy", 32'(busy), 32'd1);
    for (int d = 0; d < delay; d++) begin
      chk("ar_wait_arready", 32'(arready), 32'd0);
      chk("ar_wait_m_rready", 32'(m_rready), 32'd0);
      tick();
      chk("ar_hold", 32'(m_arvalid), 32'd1);
    end
    m_arready = 1'b1;
    #1;
    chk("ar_hs_arready", 32'(arready), 32'(1 << exp_g));
    exp_cnt[exp_g]++;
    for (int b = 0; b <= int'(len); b++) exp_q.push_back(data_of(exp_g, idx, b));
    tick();
    m_arready = 1'b0;
    arvalid[exp_g] = 1'b0;
  endtask

  // driver: R beats with optional stall / gaps; abort_at >= 0 applies reset there
  task automatic data_phase(input int exp_g, input logic [7:0] len, input int idx,
                            input int stall_at, input int stall_len, input bit gaps,
                            input int abort_at);
    int beat;
    int stall;
    logic rr_g;
    logic rv;
    logic [N-1:0] exp_rv;
    logic [DW-1:0] e;
    beat = 0;
    stall = 0;
    for (int cyc = 0; cyc < 200 && beat <= int'(len); cyc++) begin
      if (beat == abort_at) begin
        m_rvalid = 1'b1;
        rready = '1;
        m_rdata = data_of(exp_g, idx, beat);
        rst_n = 1'b0;
        #1;
        chk("rst_m_arvalid", 32'(m_arvalid), 32'd0);
        chk("rst_m_rready", 32'(m_rready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        model_reset();
        m_rvalid = 1'b0;
        m_rlast = 1'b0;
        rready = '0;
        arvalid = '0;
        tick();
        rst_n = 1'b1;
        return;
      end
      rv = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      rr_g = 1'b1;
      if (beat == stall_at && stall < stall_len) begin
        rr_g = 1'b0;
        stall++;
      end else if (gaps && $urandom_range(0, 4) == 0) begin
        rr_g = 1'b0;
      end
      rready = N'($urandom);
      rready[exp_g] = rr_g;
      m_rvalid = rv;
      m_rdata = data_of(exp_g, idx, beat);
      m_rlast = (beat == int'(len));
      #1;
      exp_rv = '0;
      if (rv) exp_rv[exp_g] = 1'b1;
      chk("r_m_rready", 32'(m_rready), 32'(rr_g));
      chk("r_rvalid", 32'(rvalid), 32'(exp_rv));
      chk("r_rlast", 32'(rlast), 32'(beat == int'(len)));
      chk("r_busy", 32'(busy), 32'd1);
      if (rv && rr_g) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", rdata, e);
        end
        beat++;
      end
      tick();
    end
    chk("r_beats", 32'(beat), 32'(len) + 32'd1);
    // back in IDLE: a stray memory beat must not reach anyone
    m_rvalid = 1'b1;
    m_rlast = 1'b0;
    rready = '1;
    #1;
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_m_arvalid", 32'(m_arvalid), 32'd0);
    chk("post_m_rready", 32'(m_rready), 32'd0);
    chk("post_rvalid", 32'(rvalid), 32'd0);
    m_rvalid = 1'b0;
    rready = '0;
    model_ptr = (exp_g + 1) % N;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{req: 2'b11, len: 8'd3, delay: 2, stall_at: -1, stall_len: 0, exp_g: 0};
    vecs[1] = '{req: 2'b11, len: 8'd3, delay: 0, stall_at: -1, stall_len: 0, exp_g: 1};
    vecs[2] = '{req: 2'b11, len: 8'd2, delay: 1, stall_at: -1, stall_len: 0, exp_g: 0};
    vecs[3] = '{req: 2'b11, len: 8'd1, delay: 0, stall_at: -1, stall_len: 0, exp_g: 1};
    vecs[4] = '{req: 2'b01, len: 8'd3, delay: 0, stall_at: 1,  stall_len: 3, exp_g: 0};
    vecs[5] = '{req: 2'b11, len: 8'd0, delay: 0, stall_at: -1, stall_len: 0, exp_g: 1};
    vecs[6] = '{req: 2'b11, len: 8'd0, delay: 1, stall_at: -1, stall_len: 0, exp_g: 0};
    vecs[7] = '{req: 2'b10, len: 8'd2, delay: 0, stall_at: 0,  stall_len: 1, exp_g: 1};
    vecs[8] = '{req: 2'b01, len: 8'd0, delay: 0, stall_at: -1, stall_len: 0, exp_g: 0};

    // reset with busy-looking inputs: outputs must stay at reset values
    arvalid = '1; araddr = '1; arlen = '1; rready = '1;
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rlast = 1'b1;
    model_reset();
    repeat (3) tick();
    chk("rst0_arready", 32'(arready), 32'd0);
    chk("rst0_rvalid", 32'(rvalid), 32'd0);
    chk("rst0_rdata", rdata, 32'd0);
    chk("rst0_rlast", 32'(rlast), 32'd0);
    chk("rst0_m_arvalid", 32'(m_arvalid), 32'd0);
    chk("rst0_m_araddr", m_araddr, 32'd0);
    chk("rst0_m_arlen", 32'(m_arlen), 32'd0);
    chk("rst0_m_arsize", 32'(m_arsize), 32'd2);
    chk("rst0_m_arburst", 32'(m_arburst), 32'd1);
    chk("rst0_m_rready", 32'(m_rready), 32'd0);
    chk("rst0_grant", 32'(grant), 32'd0);
    chk("rst0_busy", 32'(busy), 32'd0);
`ifdef ICACHE_RD_ARB_STATS_EN
    chk_cnt();
`endif
    arvalid = '0; araddr = '0; arlen = '0; rready = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rlast = 1'b0;
    rst_n = 1'b1;
    tick();

    // burst table
    for (int i = 0; i < 9; i++) begin
      addr_phase(vecs[i].req, vecs[i].len, vecs[i].delay, vecs[i].exp_g, i);
      data_phase(vecs[i].exp_g, vecs[i].len, i, vecs[i].stall_at, vecs[i].stall_len, 1'b0, -1);
    end

    // reset during beat 2 of 4, then req1 alone three times
    addr_phase(2'b01, 8'd3, 0, 0, 20);
    data_phase(0, 8'd3, 20, -1, 0, 1'b0, 2);
    for (int i = 0; i < 3; i++) begin
      addr_phase(2'b10, 8'd1, i, 1, 21 + i);
      data_phase(1, 8'd1, 21 + i, -1, 0, 1'b0, -1);
    end
`ifdef ICACHE_RD_ARB_STATS_EN
    chk("stats_req1", 32'(exp_cnt[1]), 32'd3);
    chk_cnt();
`endif

    // randomized bursts against the distance model
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] mask;
      logic [7:0] len;
      int g;
      mask = N'($urandom_range(1, 3));
      len = 8'($urandom_range(0, 3));
      g = model_pick(mask, model_ptr);
      addr_phase(mask, len, $urandom_range(0, 2), g, 30 + i);
      data_phase(g, len, 30 + i, -1, 0, 1'b1, -1);
    end
`ifdef ICACHE_RD_ARB_STATS_EN
    chk_cnt();
`endif
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_axi_rd_arbiter.md
Name: icache_axi_rd_arbiter

Overview:
- Shares one AXI4 read channel (AR + R) between NUM_REQ per-core instruction cache controllers in the multicore build.
- Sits between the cache miss engines and the memory-side AXI slave.
- Grants one requester at a time, round-robin. The grant is held for the whole burst, through RLAST.
- Read-only. The AW, W and B channels are not handled here.

Parameters:
- NUM_REQ, 2, number of requesting cache controllers (≥2).
- ADDR_SIZE, 32, AXI address width.
- DATA_SIZE, 32, AXI read data width.

Ports:
- i_clk  in  1  system clock
- i_areset_n  in  1  asynchronous active-low reset
- i_arvalid  in  NUM_REQ  per-requester AR valid
- i_araddr  in  NUM_REQ×ADDR_SIZE  per-requester AR address
- i_arlen  in  NUM_REQ×8  per-requester burst length (beats−1)
- o_arready  out  NUM_REQ  per-requester AR ready
- o_rvalid  out  NUM_REQ  per-requester R valid (one-hot or zero)
- o_rdata  out  DATA_SIZE  R data, broadcast to all requesters
- o_rlast  out  1  R last, broadcast
- i_rready  in  NUM_REQ  per-requester R ready
- o_m_arvalid  out  1  memory-side AR valid
- o_m_araddr  out  ADDR_SIZE  memory-side AR address
- o_m_arlen  out  8  memory-side burst length
- o_m_arsize  out  3  constant 2 (4-byte beats)
- o_m_arburst  out  2  constant INCR
- i_m_arready  in  1  memory-side AR ready
- i_m_rvalid  in  1  memory-side R valid
- i_m_rdata  in  DATA_SIZE  memory-side R data
- i_m_rlast  in  1  memory-side R last
- o_m_rready  out  1  memory-side R ready
- o_grant  out  $clog2(NUM_REQ)  index of the current owner (debug)
- o_busy  out  1  high in ADDR and DATA states

Behaviour:
- Reset values (asynchronous, i_areset_n low):
  - state = IDLE, round-robin pointer rr_ptr = 0, grant = 0.
  - Every output is 0, except o_m_arsize = 2 and o_m_arburst = INCR.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any i_arvalid is high, select the first requester at or after rr_ptr, scanning upward and wrapping modulo NUM_REQ.
  - On the next clock, register grant, i_araddr[grant] and i_arlen[grant], and move to ADDR.
  - No AR handshake happens in IDLE. All o_arready are 0.
- ADDR:
  - o_m_arvalid = 1, driven from the registered addr/len.
  - o_arready[grant] = i_m_arready, combinational pass-through. All other o_arready are 0.
  - When i_m_arready is high, move to DATA.
  - A requester that deasserts i_arvalid while in ADDR is a protocol violation. The arbiter does not abort the request.
- DATA:
  - o_m_rready = i_rready[grant].
  - o_rvalid[grant] = i_m_rvalid. All other o_rvalid are 0.
  - o_rdata = i_m_rdata and o_rlast = i_m_rlast, both combinational.
  - On a beat that is valid, ready and last, move to IDLE and set rr_ptr = (grant+1) mod NUM_REQ.
- Outside DATA: o_m_rready = 0 and all o_rvalid are 0.
- Latency: i_arvalid first high in cycle 0 (state IDLE) → o_m_arvalid high in cycle 1. After the last R beat, the next grant's AR can issue 2 cycles later (IDLE, then ADDR).
- Fairness: a requester waits at most NUM_REQ−1 bursts.
- Simultaneous requests: resolved by rr_ptr only. The lowest index does not win by default.
- i_arvalid changes after the grant is latched have no effect until the next IDLE.
- Back-pressure: if i_rready[grant] is low, o_m_rready is low and the beat stalls. No data is dropped and no buffering is done.
- A burst of 1 beat (arlen = 0) ends on its first beat.
- Reset mid-burst: immediate return to IDLE with all outputs at reset values. The memory slave is reset by the same i_areset_n.

Optional Feature:
- Macro: ICACHE_RD_ARB_STATS_EN.
- When defined:
  - Adds output o_grant_cnt, NUM_REQ×32 bits.
  - Counter [g] increments once per completed AR handshake for requester g and saturates at 32'hFFFF_FFFF.
  - Counters reset to 0.
- When undefined: the port and counters are absent. Arbitration behaviour is identical in both builds.

Test Plan:
- NUM_REQ=2; only req0 arvalid, addr 0x0000_1000, arlen 3; memory gives arready after 2 cycles, then 4 beats 0xA0..0xA3 → o_m_araddr = 0x1000 and o_m_arlen = 3; req0 receives 4 o_rvalid beats, rlast on 0xA3; o_rvalid[1] never high.
- req0 and req1 assert in the same cycle after reset → req0 served first, then req1; then both re-request → req0 is served next (rr_ptr wrapped to 0 after req1); the order alternates 0,1,0,1 over 4 bursts.
- In DATA, hold i_rready[grant] low for 3 cycles mid-burst → o_m_rready low for those 3 cycles; all 4 beats are delivered in order with none lost.
- arlen = 0 single-beat burst → return to IDLE 1 cycle after the beat with rlast; the next pending request gets o_m_arvalid 2 cycles after that beat.
- Assert reset during DATA beat 2 of 4 → the same cycle shows o_m_arvalid = 0, o_m_rready = 0, o_rvalid = 0 and o_busy = 0; after release, a new req1 is granted first (rr_ptr = 0, req0 idle).
- With ICACHE_RD_ARB_STATS_EN defined, issue 3 bursts from req1 → o_grant_cnt[1] = 3 and o_grant_cnt[0] = 0.
